// File: rtl/branch_predict_tournament_pkg.sv
// Shared counter encodings, reset values and saturating update
// for the tournament branch predictor tables.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  localparam ctr_t PHT_RST = CTR_WT;
  localparam ctr_t CHT_RST = CTR_WNT;

  function automatic ctr_t sat_next(
    input ctr_t c,
    input logic up
  );
    ctr_t n;
    n = c;
    unique case (1'b1)
      up && (c != CTR_ST):  n = c + 2'd1;
      !up && (c != CTR_SNT): n = c - 2'd1;
      default:               n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predict_tournament_sat_ctr_table.sv
// Table of 2-bit saturating counters: async read,
// sync inc/dec write, sync reset to RST_VAL.
module sat_ctr_table
  import bp_pkg::*;
#(
  parameter int   IDX_W   = 8,
  parameter ctr_t RST_VAL = PHT_RST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] raddr,
  output ctr_t             rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic             up
);

  ctr_t mem [2**IDX_W];

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**IDX_W; i++)
        mem[i] <= RST_VAL;
    end else if (we) begin
      mem[waddr] <= sat_next(mem[waddr], up);
    end
  end

endmodule

// File: rtl/branch_predict_tournament.sv
// Tournament predictor: per-PC local history, gshare global,
// and a per-PC chooser; GHR is speculative with M-stage repair.
module branch_predict_tournament
  import bp_pkg::*;
#(
  parameter int LHT_BITS    = 10,
  parameter int LHIST_LEN   = 6,
  parameter int GHIST_LEN   = 8,
  parameter int CHOICE_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallD,
  input  logic [31:0]          pcD,
  input  logic                 branchD,
  input  logic [31:0]          pcM,
  input  logic                 branchM,
  input  logic                 actual_takeM,
  input  logic                 pred_takeM,
  input  logic                 local_predM,
  input  logic                 global_predM,
  input  logic [GHIST_LEN-1:0] ghr_snapM,
  output logic                 pred_takeD,
  output logic                 local_predD,
  output logic                 global_predD,
  output logic [GHIST_LEN-1:0] ghr_snapD,
  output logic                 mispredictM
);

  logic [GHIST_LEN-1:0] ghr;
  logic [LHIST_LEN-1:0] lht [2**LHT_BITS];

  logic [LHT_BITS-1:0]    lht_idx_d, lht_idx_m;
  logic [LHIST_LEN-1:0]   lhist_d, lhist_m;
  logic [GHIST_LEN-1:0]   gidx_d, gidx_m;
  logic [CHOICE_BITS-1:0] cidx_d, cidx_m;
  ctr_t lpht_q, gpht_q, cht_q;
  logic cht_we;
  logic unused_pc;

  assign unused_pc = ^{pcD, pcM};

  assign lht_idx_d = pcD[LHT_BITS+1:2];
  assign lht_idx_m = pcM[LHT_BITS+1:2];
  assign lhist_d   = lht[lht_idx_d];
  assign lhist_m   = lht[lht_idx_m];
  assign gidx_d    = pcD[GHIST_LEN+1:2] ^ ghr;
  assign gidx_m    = pcM[GHIST_LEN+1:2] ^ ghr_snapM;
  assign cidx_d    = pcD[CHOICE_BITS+1:2];
  assign cidx_m    = pcM[CHOICE_BITS+1:2];

  assign local_predD  = branchD & lpht_q[1];
  assign global_predD = branchD & gpht_q[1];
  assign pred_takeD   = branchD &
                        (cht_q[1] ? gpht_q[1] : lpht_q[1]);
  assign ghr_snapD    = ghr;

  assign mispredictM = branchM & (actual_takeM ^ pred_takeM);
  assign cht_we      = branchM & (local_predM ^ global_predM);

  sat_ctr_table #(
    .IDX_W  (LHIST_LEN),
    .RST_VAL(PHT_RST)
  ) u_lpht (
    .clk  (clk),
    .rst  (rst),
    .raddr(lhist_d),
    .rdata(lpht_q),
    .we   (branchM),
    .waddr(lhist_m),
    .up   (actual_takeM)
  );

  sat_ctr_table #(
    .IDX_W  (GHIST_LEN),
    .RST_VAL(PHT_RST)
  ) u_gpht (
    .clk  (clk),
    .rst  (rst),
    .raddr(gidx_d),
    .rdata(gpht_q),
    .we   (branchM),
    .waddr(gidx_m),
    .up   (actual_takeM)
  );

  sat_ctr_table #(
    .IDX_W  (CHOICE_BITS),
    .RST_VAL(CHT_RST)
  ) u_cht (
    .clk  (clk),
    .rst  (rst),
    .raddr(cidx_d),
    .rdata(cht_q),
    .we   (cht_we),
    .waddr(cidx_m),
    .up   (global_predM == actual_takeM)
  );

  // Repair from the M-stage snapshot wins over a speculative D shift.
  always_ff @(posedge clk) begin
    if (rst)
      ghr <= '0;
    else if (mispredictM)
      ghr <= {ghr_snapM[GHIST_LEN-2:0], actual_takeM};
    else if (branchD && !stallD)
      ghr <= {ghr[GHIST_LEN-2:0], pred_takeD};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**LHT_BITS; i++)
        lht[i] <= '0;
    end else if (branchM) begin
      lht[lht_idx_m] <= {lhist_m[LHIST_LEN-2:0], actual_takeM};
    end
  end

endmodule

// File: tb/tb_branch_predict_tournament.sv
// Directed + random bench for branch_predict_tournament against
// an integer-array reference model of the predictor tables.
module tb_branch_predict_tournament;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallD = 1'b0;
  logic [31:0] pcD = '0;
  logic        branchD = 1'b0;
  logic [31:0] pcM = '0;
  logic        branchM = 1'b0;
  logic        actual_takeM = 1'b0;
  logic        pred_takeM = 1'b0;
  logic        local_predM = 1'b0;
  logic        global_predM = 1'b0;
  logic [7:0]  ghr_snapM = '0;
  logic        pred_takeD, local_predD, global_predD;
  logic [7:0]  ghr_snapD;
  logic        mispredictM;

  int n_cmp = 0;
  int n_err = 0;

  branch_predict_tournament dut (
    .clk         (clk),
    .rst         (rst),
    .stallD      (stallD),
    .pcD         (pcD),
    .branchD     (branchD),
    .pcM         (pcM),
    .branchM     (branchM),
    .actual_takeM(actual_takeM),
    .pred_takeM  (pred_takeM),
    .local_predM (local_predM),
    .global_predM(global_predM),
    .ghr_snapM   (ghr_snapM),
    .pred_takeD  (pred_takeD),
    .local_predD (local_predD),
    .global_predD(global_predD),
    .ghr_snapD   (ghr_snapD),
    .mispredictM (mispredictM)
  );

  always #5 clk = ~clk;

  // Reference model: counters are plain ints 0..3, histories ints.
  int m_lht  [1024];
  int m_lpht [64];
  int m_gpht [256];
  int m_cht  [256];
  int m_ghr;

  function automatic int sat(input int c, input bit up);
    if (up) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic int lidx(input int unsigned pc);
    return int'((pc >> 2) % 1024);
  endfunction

  function automatic int gsh(input int unsigned pc, input int h);
    return int'((pc >> 2) % 256) ^ h;
  endfunction

  function automatic int cix(input int unsigned pc);
    return int'((pc >> 2) % 256);
  endfunction

  task automatic model_pred(output bit l, output bit g, output bit p);
    bit lt, gt;
    lt = m_lpht[m_lht[lidx(pcD)]] >= 2;
    gt = m_gpht[gsh(pcD, m_ghr)] >= 2;
    l = branchD && lt;
    g = branchD && gt;
    p = branchD && ((m_cht[cix(pcD)] >= 2) ? gt : lt);
  endtask

  task automatic model_edge();
    bit l, g, p, mis;
    int h;
    model_pred(l, g, p);
    if (rst) begin
      foreach (m_lht[i])  m_lht[i]  = 0;
      foreach (m_lpht[i]) m_lpht[i] = 2;
      foreach (m_gpht[i]) m_gpht[i] = 2;
      foreach (m_cht[i])  m_cht[i]  = 1;
      m_ghr = 0;
      return;
    end
    mis = branchM && (actual_takeM != pred_takeM);
    if (branchM) begin
      h = m_lht[lidx(pcM)];
      m_lpht[h] = sat(m_lpht[h], actual_takeM);
      m_lht[lidx(pcM)] = (h * 2 + int'(actual_takeM)) % 64;
      m_gpht[gsh(pcM, int'(ghr_snapM))] =
        sat(m_gpht[gsh(pcM, int'(ghr_snapM))], actual_takeM);
      if (local_predM != global_predM)
        m_cht[cix(pcM)] = sat(m_cht[cix(pcM)],
                              global_predM == actual_takeM);
    end
    if (mis)
      m_ghr = (int'(ghr_snapM) * 2 + int'(actual_takeM)) % 256;
    else if (branchD && !stallD)
      m_ghr = (m_ghr * 2 + int'(p)) % 256;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit l, g, p;
    model_pred(l, g, p);
    chk({tag, ".pred"},   32'(pred_takeD),   32'(p));
    chk({tag, ".local"},  32'(local_predD),  32'(l));
    chk({tag, ".global"}, 32'(global_predD), 32'(g));
    chk({tag, ".snap"},   32'(ghr_snapD),    32'(m_ghr));
    chk({tag, ".mis"},    32'(mispredictM),
        32'(branchM && (actual_takeM != pred_takeM)));
  endtask

  task automatic step(input string tag, input bit do_chk);
    #1;
    if (do_chk) check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic m_idle();
    branchM = 0; pcM = '0; actual_takeM = 0; pred_takeM = 0;
    local_predM = 0; global_predM = 0; ghr_snapM = '0;
  endtask

  initial begin
    bit l, g, p;
    logic [7:0] g0;
    // reset with a branch waiting in D
    branchD = 1; pcD = 32'h100;
    step("rst0", 0);
    #1;
    chk("rst.pred_during", 32'(pred_takeD), 32'd1);
    step("rst1", 1);
    rst = 0;
    stallD = 1;
    #1;
    chk("r22.pred",  32'(pred_takeD),  32'd1);
    chk("r22.local", 32'(local_predD), 32'd1);
    chk("r22.snap",  32'(ghr_snapD),   32'd0);
    step("r22", 1);

    // three not-taken resolutions at 0x100, prediction matching
    branchD = 0; stallD = 0;
    branchM = 1; pcM = 32'h100; actual_takeM = 0; pred_takeM = 0;
    local_predM = 0; global_predM = 0;
    repeat (3) step("r23", 1);
    m_idle();
    branchD = 1; pcD = 32'h100; stallD = 1;
    #1;
    chk("r23.local_nt", 32'(local_predD), 32'd0);
    chk("r23.lpht0",    32'(m_lpht[0]),   32'd0);

    // stalled branch for three cycles: GHR and prediction frozen
    g0 = ghr_snapD;
    p = pred_takeD;
    repeat (3) begin
      step("r25", 1);
      chk("r25.ghr",  32'(ghr_snapD),  32'(g0));
      chk("r25.pred", 32'(pred_takeD), 32'(p));
    end

    // repair beats a same-cycle D shift
    stallD = 0;
    branchM = 1; pcM = 32'h400; actual_takeM = 0; pred_takeM = 1;
    local_predM = 1; global_predM = 1; ghr_snapM = 8'hA5;
    step("r24", 1);
    chk("r24.ghr", 32'(ghr_snapD), 32'h4A);

    // chooser trains toward global at 0x200
    branchD = 0;
    branchM = 1; pcM = 32'h200; actual_takeM = 0; pred_takeM = 0;
    local_predM = 1; global_predM = 0; ghr_snapM = 8'h00;
    step("r26a", 1);
    chk("r26.cht1", 32'(m_cht[cix(32'h200)]), 32'd2);
    step("r26b", 1);
    chk("r26.cht2", 32'(m_cht[cix(32'h200)]), 32'd3);
    m_idle();
    branchD = 1; pcD = 32'h200; stallD = 1;
    #1;
    chk("r26.sel_global", 32'(pred_takeD), 32'(global_predD));
    step("r26c", 1);

    // alternating branch at 0x300 trains the local predictor
    stallD = 0;
    for (int i = 0; i < 40; i++) begin
      bit act;
      act = i[0] ? 1'b0 : 1'b1;
      m_idle();
      branchD = 1; pcD = 32'h300;
      #1;
      model_pred(l, g, p);
      if (i >= 16) chk("r27.local_acc", 32'(local_predD), 32'(act));
      g0 = ghr_snapD;
      step("r27d", 1);
      branchD = 0;
      branchM = 1; pcM = 32'h300; actual_takeM = act;
      pred_takeM = p; local_predM = l; global_predM = g;
      ghr_snapM = 8'(m_ghr);
      step("r27m", 1);
    end

    // random traffic over a few aliasing PCs
    for (int i = 0; i < 400; i++) begin
      int unsigned pcs [5];
      pcs = '{32'h100, 32'h104, 32'h200, 32'h300, 32'h1100};
      rst = ($urandom_range(0, 59) == 0);
      stallD = $urandom_range(0, 3) == 0;
      branchD = $urandom_range(0, 1);
      pcD = pcs[$urandom_range(0, 4)];
      branchM = $urandom_range(0, 1);
      pcM = pcs[$urandom_range(0, 4)];
      actual_takeM = $urandom_range(0, 1);
      pred_takeM = $urandom_range(0, 1);
      local_predM = $urandom_range(0, 1);
      global_predM = $urandom_range(0, 1);
      ghr_snapM = 8'($urandom_range(0, 255));
      step("rnd", 1);
    end

    rst = 0;
    m_idle();
    branchD = 0;
    step("end", 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predict_tournament.md
BRANCH_PREDICT_TOURNAMENT -- requirements
Module: branch_predict_tournament

Interface
REQ-001 SHALL have parameter LHT_BITS, default 10, meaning the local history table index width (entries = 2^LHT_BITS).
REQ-002 SHALL have parameter LHIST_LEN, default 6, meaning the local history length and the local PHT index width.
REQ-003 SHALL have parameter GHIST_LEN, default 8, meaning the global history length and the gshare PHT index width.
REQ-004 SHALL have parameter CHOICE_BITS, default 8, meaning the chooser table index width.
REQ-005 SHALL have the following ports, one per line:
  clk  in  1  clock, all state updates on rising edge
  rst  in  1  synchronous active-high reset
  stallD  in  1  decode stall; a stalled D-stage branch does not shift GHR
  pcD  in  32  PC of the decode-stage instruction
  branchD  in  1  decode-stage instruction is a conditional branch
  pcM  in  32  PC of the memory-stage instruction
  branchM  in  1  memory-stage instruction is a conditional branch
  actual_takeM  in  1  resolved direction
  pred_takeM  in  1  final prediction piped from D
  local_predM  in  1  local component prediction piped from D
  global_predM  in  1  global component prediction piped from D
  ghr_snapM  in  GHIST_LEN  GHR snapshot piped from D
  pred_takeD  out  1  final prediction
  local_predD  out  1  local component prediction
  global_predD  out  1  global component prediction
  ghr_snapD  out  GHIST_LEN  GHR value used for this prediction
  mispredictM  out  1  branchM & (actual_takeM != pred_takeM)

Function
REQ-006 SHALL use 2-bit saturating binary counters for all PHT and chooser entries: 00 (strongly not taken) up to 11 (strongly taken); MSB = taken; for the chooser, MSB = use global.
REQ-007 SHALL compute the local prediction as MSB of LPHT[LHT[pcD[LHT_BITS+1:2]]].
REQ-008 SHALL compute the global prediction as MSB of GPHT[pcD[GHIST_LEN+1:2] ^ GHR].
REQ-009 SHALL select pred_takeD = branchD & (CHT[pcD[CHOICE_BITS+1:2]][1] ? global : local); local_predD and global_predD are likewise gated by branchD; ghr_snapD = GHR; all are combinational, 0-cycle latency.
REQ-010 SHALL, on branchD & ~stallD & ~mispredictM, shift GHR: GHR <= {GHR[GHIST_LEN-2:0], pred_takeD}.
REQ-011 SHALL, on mispredictM, repair GHR: GHR <= {ghr_snapM[GHIST_LEN-2:0], actual_takeM}; repair has priority over the REQ-010 shift in the same cycle.
REQ-012 SHALL, on branchM, shift actual_takeM into LHT[pcM[LHT_BITS+1:2]] and update LPHT at the pre-shift local history toward actual_takeM.
REQ-013 SHALL, on branchM, update GPHT[pcM[GHIST_LEN+1:2] ^ ghr_snapM] toward actual_takeM.
REQ-014 SHALL, on branchM with local_predM != global_predM, increment CHT[pcM[CHOICE_BITS+1:2]] if global_predM == actual_takeM, else decrement; no update when they agree.
REQ-015 SHALL saturate counters (no wrap at 00 or 11).
REQ-016 SHALL give D-stage reads pre-edge contents when D and M address the same entry in the same cycle (no write bypass).
REQ-017 SHALL ignore all M-stage inputs while branchM=0; mispredictM SHALL then be 0.

Reset
REQ-018 SHALL, on rst, set all LHT entries and GHR to 0, LPHT and GPHT entries to 2'b10, and CHT entries to 2'b01; rst SHALL override any same-cycle update.
REQ-019 SHALL assert pred_takeD = 1 during and after reset for any branchD (LPHT at 10, chooser selects local).

Structure
REQ-020 SHALL place the counter encodings, reset values and the 2-bit saturating next-state function in shared package bp_pkg.
REQ-021 SHALL instantiate sub-module sat_ctr_table three times (LPHT, GPHT, CHT): parametrised index width, one async read port, one sync inc/dec write port, sync reset to a parameter value.

Verification
REQ-022 SHALL cover: reset, then branchD=1, pcD=0x100 -> pred_takeD=1, local_predD=1, ghr_snapD=0.
REQ-023 SHALL cover: pcM=0x100 resolved not-taken 3 times with pred_takeM matching -> LPHT entry 00, LHT[0x40]=0.
REQ-024 SHALL cover: branchD & mispredictM in the same cycle with ghr_snapM=8'hA5, actual_takeM=0 -> GHR=8'h4A next cycle; the D shift is discarded.
REQ-025 SHALL cover: stallD=1 with branchD=1 for 3 cycles -> GHR unchanged, pred_takeD stable.
REQ-026 SHALL cover: local_predM=1, global_predM=0, actual_takeM=0 twice at pcM=0x200 -> CHT entry 01->10->11; a subsequent pcD=0x200 uses the global prediction.
REQ-027 SHALL cover: alternating taken/not-taken branch at one PC for 40 resolutions -> local predictor reaches 100% accuracy after warm-up.
